// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register writers per stage and
// raises stall/forwarding controls for the D stage, plus a multiply/divide busy counter.
module hazard_scoreboard #(
  parameter int unsigned NSTG     = 2,
  parameter int unsigned TW       = 3,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [4:0]    rs_d,
  input  logic [4:0]    rt_d,
  input  logic [TW-1:0] tuse_rs,
  input  logic [TW-1:0] tuse_rt,
  input  logic [4:0]    wa_d,
  input  logic          we_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          md_start_d,
  input  logic          md_div_d,
  input  logic          md_use_d,
  output logic          stall,
  output logic          stall_rs,
  output logic          stall_rt,
  output logic          stall_md,
  output logic          md_busy,
  output logic [2:0]    fwd_rs,
  output logic [2:0]    fwd_rt
);

  localparam int unsigned CW = 8;
  localparam int unsigned FW = 3;

  logic          stg_we_q   [1:NSTG];
  logic [4:0]    stg_wa_q   [1:NSTG];
  logic [TW-1:0] stg_tnew_q [1:NSTG];
  logic          stg_we_d   [1:NSTG];
  logic [4:0]    stg_wa_d   [1:NSTG];
  logic [TW-1:0] stg_tnew_d [1:NSTG];
  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;

  // Hazard detection and forwarding select; scanning oldest to youngest lets the youngest producer win.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    fwd_rs   = '0;
    fwd_rt   = '0;
    for (int k = int'(NSTG); k >= 1; k--) begin
      if (stg_we_q[k] && (stg_wa_q[k] != 5'd0)) begin
        if (stg_wa_q[k] == rs_d) begin
          fwd_rs = FW'(k);
          if (stg_tnew_q[k] > tuse_rs) stall_rs = 1'b1;
        end
        if (stg_wa_q[k] == rt_d) begin
          fwd_rt = FW'(k);
          if (stg_tnew_q[k] > tuse_rt) stall_rt = 1'b1;
        end
      end
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign stall_md = md_use_d & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // Stage advance: older entries age their Tnew, a stall injects a bubble into stage 1.
  always_comb begin
    for (int k = 1; k <= int'(NSTG); k++) begin
      stg_we_d[k]   = 1'b0;
      stg_wa_d[k]   = '0;
      stg_tnew_d[k] = '0;
    end
    if (!flush) begin
      for (int k = int'(NSTG); k >= 2; k--) begin
        stg_we_d[k]   = stg_we_q[k-1];
        stg_wa_d[k]   = stg_wa_q[k-1];
        stg_tnew_d[k] = (stg_tnew_q[k-1] != '0) ? stg_tnew_q[k-1] - TW'(1) : '0;
      end
      if (!stall) begin
        stg_we_d[1]   = we_d;
        stg_wa_d[1]   = wa_d;
        stg_tnew_d[1] = tnew_d;
      end
    end
  end

  // MDU busy counter: a start is accepted only when D is not stalled.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (flush) begin
      md_cnt_d = '0;
    end else if (md_start_d && !stall) begin
      md_cnt_d = md_div_d ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= int'(NSTG); k++) begin
        stg_we_q[k]   <= 1'b0;
        stg_wa_q[k]   <= '0;
        stg_tnew_q[k] <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      for (int k = 1; k <= int'(NSTG); k++) begin
        stg_we_q[k]   <= stg_we_d[k];
        stg_wa_q[k]   <= stg_wa_d[k];
        stg_tnew_q[k] <= stg_tnew_d[k];
      end
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed pipeline scenarios, expectations queued
// when D inputs are driven and compared against the outputs mid-cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic [4:0] rs_d, rt_d, wa_d;
  logic [2:0] tuse_rs, tuse_rt, tnew_d;
  logic       we_d, md_start_d, md_div_d, md_use_d;
  logic       stall, stall_rs, stall_rt, stall_md, md_busy;
  logic [2:0] fwd_rs, fwd_rt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } exp_t;
  exp_t exp_q[$];

  hazard_scoreboard #(.NSTG(2), .TW(3), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .wa_d(wa_d), .we_d(we_d), .tnew_d(tnew_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt), .stall_md(stall_md),
    .md_busy(md_busy), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {stall, stall_rs, stall_rt, stall_md, md_busy, fwd_rs, fwd_rt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Expected output vector; overall stall is the OR of its three causes.
  function automatic logic [10:0] ex(input logic srs, input logic srt, input logic smd,
                                     input logic bsy, input logic [2:0] frs, input logic [2:0] frt);
    return {srs | srt | smd, srs, srt, smd, bsy, frs, frt};
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [2:0] tus, input logic [4:0] rt,
                       input logic [2:0] tut, input logic we, input logic [4:0] wa,
                       input logic [2:0] tn);
    rs_d = rs; tuse_rs = tus; rt_d = rt; tuse_rt = tut;
    we_d = we; wa_d = wa; tnew_d = tn;
  endtask

  task automatic set_md(input logic st, input logic dv, input logic us);
    md_start_d = st; md_div_d = dv; md_use_d = us;
  endtask

  // One D cycle: queue the expectation, then let the edge happen.
  task automatic cyc(input string tag, input logic [10:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      check(it.tag, 32'(obs), 32'(it.exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    set_d(5, 0, 5, 0, 1, 5, 3);
    set_md(1, 1, 1);
    #3;
    check("reset_outputs", 32'(obs), 32'(0));
    set_d(0, 0, 0, 0, 0, 0, 0);
    set_md(0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // load-use: tnew 2 in E against tuse 1
    set_d(0, 0, 0, 0, 1, 8, 2); cyc("lu_issue", ex(0, 0, 0, 0, 0, 0));
    set_d(8, 1, 0, 0, 0, 0, 0); cyc("lu_stall", ex(1, 0, 0, 0, 1, 0));
    cyc("lu_fwd_m", ex(0, 0, 0, 0, 2, 0));
    set_d(0, 0, 0, 0, 0, 0, 0); cyc("lu_drain", ex(0, 0, 0, 0, 0, 0));

    // ALU back-to-back on rt
    set_d(0, 0, 0, 0, 1, 5, 1); cyc("alu_issue1", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 5, 1, 0, 0, 0); cyc("alu_tuse1", ex(0, 0, 0, 0, 0, 1));
    set_d(0, 0, 0, 0, 0, 0, 0); cyc("alu_gap", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 0, 0, 1, 5, 1); cyc("alu_issue2", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 5, 0, 0, 0, 0); cyc("alu_tuse0", ex(0, 1, 0, 0, 0, 1));
    cyc("alu_tuse0_rel", ex(0, 0, 0, 0, 0, 2));
    set_d(0, 0, 0, 0, 0, 0, 0); cyc("alu_drain", ex(0, 0, 0, 0, 0, 0));

    // youngest producer wins; wa=0 and we=0 entries never match
    set_d(0, 0, 0, 0, 1, 3, 0); cyc("yw_issue", ex(0, 0, 0, 0, 0, 0));
    set_d(3, 0, 0, 0, 1, 3, 0); cyc("yw_e_only", ex(0, 0, 0, 0, 1, 0));
    set_d(3, 0, 0, 0, 0, 0, 0); cyc("yw_both", ex(0, 0, 0, 0, 1, 0));
    cyc("yw_m_only", ex(0, 0, 0, 0, 2, 0));
    set_d(0, 0, 0, 0, 1, 0, 2); cyc("r0_issue", ex(0, 0, 0, 0, 0, 0));
    cyc("r0_e", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 0, 0, 0, 0, 0); cyc("r0_both", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 0, 0, 0, 9, 3); cyc("nowe_issue", ex(0, 0, 0, 0, 0, 0));
    set_d(9, 0, 9, 0, 0, 0, 0); cyc("nowe_match", ex(0, 0, 0, 0, 0, 0));
    set_d(0, 0, 0, 0, 0, 0, 0); cyc("nowe_drain", ex(0, 0, 0, 0, 0, 0));

    // divide, then a multiply held off until the divide completes
    set_md(1, 1, 1); cyc("div_issue", ex(0, 0, 0, 0, 0, 0));
    set_md(1, 0, 1);
    for (int i = 0; i < 10; i++) cyc($sformatf("div_busy%0d", i), ex(0, 0, 1, 1, 0, 0));
    cyc("mult_issue", ex(0, 0, 0, 0, 0, 0));
    set_md(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc($sformatf("mult_busy%0d", i), ex(0, 0, 1, 1, 0, 0));
    cyc("mult_done", ex(0, 0, 0, 0, 0, 0));

    // flush clears the stages and the MDU counter
    set_md(1, 0, 1); cyc("fl_mult", ex(0, 0, 0, 0, 0, 0));
    set_md(0, 0, 0); set_d(0, 0, 0, 0, 1, 7, 2); cyc("fl_load", ex(0, 0, 0, 1, 0, 0));
    set_d(7, 0, 0, 0, 0, 0, 0); flush = 1'b1; cyc("fl_pre", ex(1, 0, 0, 1, 1, 0));
    flush = 1'b0; set_md(0, 0, 1); cyc("fl_post", ex(0, 0, 0, 0, 0, 0));
    set_md(1, 1, 1); set_d(0, 0, 0, 0, 1, 7, 2); flush = 1'b1; cyc("fl_both", ex(0, 0, 0, 0, 0, 0));
    flush = 1'b0; set_md(0, 0, 1); set_d(7, 0, 0, 0, 0, 0, 0); cyc("fl_prio", ex(0, 0, 0, 0, 0, 0));
    set_md(0, 0, 0); set_d(0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a stall
    set_d(0, 0, 0, 0, 1, 4, 3); cyc("ar_issue", ex(0, 0, 0, 0, 0, 0));
    set_d(4, 0, 0, 0, 1, 6, 1);
    begin
      exp_t it;
      it.tag = "ar_stall";
      it.exp = ex(1, 0, 0, 0, 1, 0);
      exp_q.push_back(it);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_async", 32'(obs), 32'(0));
    set_d(6, 0, 0, 0, 1, 6, 1);
    @(posedge clk);
    #1;
    check("ar_held", 32'(obs), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    set_d(6, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cyc("ar_release", ex(0, 0, 0, 0, 0, 0));

    check("queue_drain", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
